// File: rtl/hmc830_pkg.sv
//==============================================================================
// Module   : hmc830_pkg
// Brief    : HMC830 register/chip-address defaults, sequencer state codes and
//            the Open-Mode frame builder.
// Revision : 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

package hmc830_pkg;

    localparam logic [2:0] c_CHIP_ADDR = 3'b000;
    localparam logic [4:0] c_REG_INT   = 5'h03;
    localparam logic [4:0] c_REG_FRAC  = 5'h04;

    localparam int         c_ST_W      = 3;
    localparam logic [c_ST_W-1:0] c_ST_IDLE  = 3'd0;
    localparam logic [c_ST_W-1:0] c_ST_LOAD  = 3'd1;
    localparam logic [c_ST_W-1:0] c_ST_SHIFT = 3'd2;
    localparam logic [c_ST_W-1:0] c_ST_LATCH = 3'd3;
    localparam logic [c_ST_W-1:0] c_ST_GAP   = 3'd4;
    localparam logic [c_ST_W-1:0] c_ST_DONE  = 3'd5;

    // Frame = {data[23:0], reg[4:0], chip[2:0]}; the integer write carries N zero-extended.
    function automatic logic [31:0] build_frame(
        input logic        sel_frac,
        input logic [31:0] word,
        input logic [4:0]  reg_int,
        input logic [4:0]  reg_frac,
        input logic [2:0]  chip_addr
    );
        if (sel_frac) begin
            return {word[23:0], reg_frac, chip_addr};
        end
        return {16'h0000, word[31:24], reg_int, chip_addr};
    endfunction

endpackage

`default_nettype wire

// File: rtl/spi_frame_tx32.sv
//==============================================================================
// Module   : spi_frame_tx32
// Brief    : One 32-bit Open-Mode SPI frame: sck divider, MSB-first shifter and
//            the trailing sen latch phase.
// Revision : 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module spi_frame_tx32 #(
    parameter int CLK_DIV = 25
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] frame,
    output logic        sck,
    output logic        sdi,
    output logic        sen,
    output logic        frame_done
);

    localparam int                 c_DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);

    localparam logic [1:0] c_PH_IDLE  = 2'd0;
    localparam logic [1:0] c_PH_SHIFT = 2'd1;
    localparam logic [1:0] c_PH_LATCH = 2'd2;

    logic [1:0]         r_phase;
    logic [1:0]         w_phase_nxt;
    logic [c_DIV_W-1:0] r_div;
    logic [4:0]         r_bitcnt;
    logic [30:0]        r_shreg;
    logic               r_sck;
    logic               r_sdi;
    logic               r_sen;
    logic               r_half;
    logic               w_div_end;
    logic               w_last_bit;

    assign w_div_end  = (r_div == c_DIV_LAST);
    assign w_last_bit = (r_bitcnt == 5'd31);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase <= c_PH_IDLE;
        end else begin
            r_phase <= w_phase_nxt;
        end
    end

    always_comb begin
        w_phase_nxt = r_phase;
        case (r_phase)
            c_PH_IDLE:  if (start) w_phase_nxt = c_PH_SHIFT;
            c_PH_SHIFT: if (w_div_end && r_sck && w_last_bit) w_phase_nxt = c_PH_LATCH;
            c_PH_LATCH: if (w_div_end && r_half) w_phase_nxt = c_PH_IDLE;
            default:    w_phase_nxt = c_PH_IDLE;
        endcase
    end

    // Bit 31 goes straight to sdi at start, so the shifter only holds bits 30..0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div    <= '0;
            r_bitcnt <= '0;
            r_shreg  <= '0;
            r_sck    <= 1'b0;
            r_sdi    <= 1'b0;
            r_sen    <= 1'b0;
            r_half   <= 1'b0;
        end else begin
            case (r_phase)
                c_PH_IDLE: begin
                    r_div <= '0;
                    if (start) begin
                        r_shreg  <= frame[30:0];
                        r_sdi    <= frame[31];
                        r_bitcnt <= '0;
                        r_sck    <= 1'b0;
                        r_half   <= 1'b0;
                    end
                end
                c_PH_SHIFT: begin
                    if (!w_div_end) begin
                        r_div <= r_div + 1'b1;
                    end else begin
                        r_div <= '0;
                        if (!r_sck) begin
                            r_sck <= 1'b1;
                        end else begin
                            r_sck <= 1'b0;
                            if (w_last_bit) begin
                                r_sdi  <= 1'b0;
                                r_sen  <= 1'b1;
                                r_half <= 1'b0;
                            end else begin
                                r_bitcnt <= r_bitcnt + 1'b1;
                                r_sdi    <= r_shreg[30];
                                r_shreg  <= {r_shreg[29:0], 1'b0};
                            end
                        end
                    end
                end
                c_PH_LATCH: begin
                    if (!w_div_end) begin
                        r_div <= r_div + 1'b1;
                    end else begin
                        r_div <= '0;
                        if (!r_half) begin
                            r_half <= 1'b1;
                        end else begin
                            r_sen <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_div <= '0;
                    r_sck <= 1'b0;
                    r_sdi <= 1'b0;
                    r_sen <= 1'b0;
                end
            endcase
        end
    end

    assign sck        = r_sck;
    assign sdi        = r_sdi;
    assign sen        = r_sen;
    assign frame_done = (r_phase == c_PH_LATCH) && w_div_end && r_half;

endmodule

`default_nettype wire

// File: rtl/hmc830_spi_writer.sv
//==============================================================================
// Module   : hmc830_spi_writer
// Brief    : Turns each accepted {N, frac} word into REG03 then REG04 SPI writes
//            to the HMC830, with a one-deep last-wins pending buffer.
// Revision : 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module hmc830_spi_writer
    import hmc830_pkg::*;
#(
    parameter int         CLK_DIV   = 25,
    parameter int         GAP_CYC   = 50,
    parameter logic [2:0] CHIP_ADDR = c_CHIP_ADDR,
    parameter logic [4:0] REG_INT   = c_REG_INT,
    parameter logic [4:0] REG_FRAC  = c_REG_FRAC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] int_frac_data,
    output logic        busy,
    output logic        done,
    output logic        sck,
    output logic        sdi,
    output logic        sen
);

    localparam int                 c_GAP_W    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'(GAP_CYC - 1);

    logic [c_ST_W-1:0]  r_state;
    logic [c_ST_W-1:0]  w_state_nxt;
    logic [31:0]        r_word;
    logic [31:0]        r_pend_word;
    logic               r_pend_valid;
    logic               r_sel;
    logic [c_GAP_W-1:0] r_gap_cnt;
    logic               w_gap_end;
    logic               w_start;
    logic               w_frame_done;
    logic               w_sen;
    logic [31:0]        w_frame;

    assign w_gap_end = (r_gap_cnt == c_GAP_LAST);
    assign w_frame   = build_frame(r_sel, r_word, REG_INT, REG_FRAC, CHIP_ADDR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // SHIFT/LATCH follow the transmitter; frame_done is the only exit from either.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:  if (load || r_pend_valid) w_state_nxt = c_ST_LOAD;
            c_ST_LOAD:  w_state_nxt = c_ST_SHIFT;
            c_ST_SHIFT: begin
                if (w_frame_done)  w_state_nxt = c_ST_GAP;
                else if (w_sen)    w_state_nxt = c_ST_LATCH;
            end
            c_ST_LATCH: if (w_frame_done) w_state_nxt = c_ST_GAP;
            c_ST_GAP:   if (w_gap_end) w_state_nxt = r_sel ? c_ST_DONE : c_ST_LOAD;
            c_ST_DONE:  w_state_nxt = c_ST_IDLE;
            default:    w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_comb begin
        busy    = (r_state != c_ST_IDLE);
        done    = (r_state == c_ST_DONE);
        w_start = (r_state == c_ST_LOAD);
    end

    // A pending word beats a fresh load in IDLE; the fresh one then becomes pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_word       <= '0;
            r_pend_word  <= '0;
            r_pend_valid <= 1'b0;
            r_sel        <= 1'b0;
            r_gap_cnt    <= '0;
        end else begin
            if (r_state == c_ST_IDLE) begin
                r_sel <= 1'b0;
                if (r_pend_valid) begin
                    r_word       <= r_pend_word;
                    r_pend_valid <= load;
                    if (load) begin
                        r_pend_word <= int_frac_data;
                    end
                end else if (load) begin
                    r_word <= int_frac_data;
                end
            end else if (load) begin
                r_pend_word  <= int_frac_data;
                r_pend_valid <= 1'b1;
            end

            if (r_state == c_ST_GAP) begin
                r_gap_cnt <= w_gap_end ? '0 : r_gap_cnt + 1'b1;
                if (w_gap_end) begin
                    r_sel <= 1'b1;
                end
            end else begin
                r_gap_cnt <= '0;
            end
        end
    end

    spi_frame_tx32 #(
        .CLK_DIV (CLK_DIV)
    ) u_tx (
        .clk        (clk),
        .rst        (rst),
        .start      (w_start),
        .frame      (w_frame),
        .sck        (sck),
        .sdi        (sdi),
        .sen        (w_sen),
        .frame_done (w_frame_done)
    );

    assign sen = w_sen;

endmodule

`default_nettype wire
